// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial deserialiser and its word FIFO.
package serial_deser_pkg;

    typedef enum logic {
        StHunt  = 1'b0,
        StShift = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions; returns 1 for v <= 2.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_deser_sync_fifo.sv
// Word FIFO with a registered head: rdata_o always shows the oldest entry and
// holds the last popped word once empty.
module serial_deser_sync_fifo
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [clog2(DEPTH):0] level_o
);

    localparam int unsigned AddrW = clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [PtrW-1:0]  level;
    logic [AddrW-1:0] waddr, raddr, raddr_next;
    logic             push_ok, pop_ok;

    assign waddr      = wptr_q[AddrW-1:0];
    assign raddr      = rptr_q[AddrW-1:0];
    assign raddr_next = raddr + AddrW'(1);
    assign level      = wptr_q - rptr_q;

    // Same low bits: MSB decides whether the pointers are a lap apart.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) && (waddr == raddr);

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q + PtrW'(push_ok);
        rptr_d  = rptr_q + PtrW'(pop_ok);
        rdata_d = rdata_q;
        if (push_ok && (empty_o || (pop_ok && level == PtrW'(1)))) begin
            rdata_d = wdata_i;
        end else if (pop_ok && level > PtrW'(1)) begin
            rdata_d = mem_q[raddr_next];
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            rdata_q <= rdata_d;
            if (push_ok) begin
                mem_q[waddr] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;
    assign level_o = level;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: frame-aligned word assembly feeding a small FIFO
// with a valid/ready output, sticky overflow and a frame-error pulse.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  sin,
    input  logic                  sin_en,
    input  logic                  sync,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  clr_err
);

    localparam int unsigned CntW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] first_word, shifted_word;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full, empty;

    // A fresh word starts from zeros so stale bits never leak into it.
    assign first_word   = MSB_FIRST ? {{(WIDTH-1){1'b0}}, sin} : {sin, {(WIDTH-1){1'b0}}};
    assign shifted_word = MSB_FIRST ? {shift_q[WIDTH-2:0], sin} : {sin, shift_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (sin_en) begin
            unique case (state_q)
                StHunt: begin
                    if (sync) begin
                        shift_d = first_word;
                        cnt_d   = CntW'(1);
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (sync) begin
                        frame_err_d = (cnt_q != '0);
                        shift_d     = first_word;
                        cnt_d       = CntW'(1);
                    end else begin
                        shift_d = shifted_word;
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            push  = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
    end

    assign pop = out_valid & out_ready;

    // A same-cycle drop outranks clr_err.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= StHunt;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    serial_deser_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (push),
        .wdata_i (shift_d),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign out_valid = ~empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
